// File: rtl/i2c_read_2byte_c_if.sv
// Bus bundle for the 2-byte-pointer I2C read engine.
// The master side is the engine; the slave side is its environment.
interface i2c_read_2byte_c_if;
    logic        GO;
    logic [15:0] POINTER;
    logic [7:0]  SLAVE_ADDRESS;
    logic        SDAI;
    logic        SDAO;
    logic        SCLO;
    logic        END_OK;
    logic [15:0] RDATA;
    logic        ACK_OK;
    logic [3:0]  ST;
    logic [3:0]  CNT;
    logic [2:0]  BYTE;

    modport master (
        input  GO, POINTER, SLAVE_ADDRESS, SDAI,
        output SDAO, SCLO, END_OK, RDATA, ACK_OK, ST, CNT, BYTE
    );

    modport slave (
        output GO, POINTER, SLAVE_ADDRESS, SDAI,
        input  SDAO, SCLO, END_OK, RDATA, ACK_OK, ST, CNT, BYTE
    );
endinterface

// File: rtl/i2c_read_2byte_c.sv
// I2C master read engine: START, addr+W, 16-bit pointer, rSTART,
// addr+R, RD_BYTES data bytes, STOP. One bus phase per PT_CK edge.
module i2c_read_2byte_c #(
    parameter int RD_BYTES = 2
) (
    input logic PT_CK,
    input logic RESET,
    i2c_read_2byte_c_if.master bus
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_WBIT   = 4'd2;
    localparam logic [3:0] S_RSTART = 4'd3;
    localparam logic [3:0] S_RBIT   = 4'd4;
    localparam logic [3:0] S_STOP   = 4'd5;
    localparam logic [3:0] S_DONE   = 4'd6;

    localparam logic [2:0] LAST_BYTE = 3'(3 + RD_BYTES);

    logic [3:0]  st_q, st_d;
    logic [1:0]  ph_q, ph_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  byte_q, byte_d;
    logic [15:0] ptr_q, ptr_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] rx_q, rx_d;
    logic [15:0] rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        ack_ok_q, ack_ok_d;
    logic        sda_q, sda_d;
    logic        scl_q, scl_d;
    logic        end_ok_q, end_ok_d;
    logic        unused_addr0;

    assign unused_addr0 = bus.SLAVE_ADDRESS[0];

    // Bus levels for a given state; evaluated on next-state so SDA/SCL are flops.
    function automatic logic [1:0] bus_f(
        input logic [3:0]  st,
        input logic [1:0]  ph,
        input logic [3:0]  cnt,
        input logic [2:0]  byt,
        input logic [15:0] ptr,
        input logic [6:0]  addr
    );
        logic [7:0] tx;
        logic       scl;
        logic       sda;
        case (byt)
            3'd0:    tx = {addr, 1'b0};
            3'd1:    tx = ptr[15:8];
            3'd2:    tx = ptr[7:0];
            default: tx = {addr, 1'b1};
        endcase
        scl = 1'b1;
        sda = 1'b1;
        case (st)
            S_START: sda = 1'b0;
            S_WBIT: begin
                scl = (ph != 2'd0);
                sda = (cnt == 4'd8) ? 1'b1 : tx[~cnt[2:0]];
            end
            S_RSTART: begin
                scl = (ph != 2'd0);
                sda = (ph != 2'd2);
            end
            S_RBIT: begin
                scl = (ph != 2'd0);
                sda = (cnt != 4'd8) || (byt == LAST_BYTE);
            end
            S_STOP: begin
                scl = (ph != 2'd0);
                sda = (ph == 2'd2);
            end
            default: ;
        endcase
        return {scl, sda};
    endfunction

    always_comb begin
        st_d     = st_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        nack_d   = nack_q;
        ack_ok_d = ack_ok_q;
        case (st_q)
            S_IDLE: begin
                if (bus.GO) begin
                    st_d     = S_START;
                    ptr_d    = bus.POINTER;
                    addr_d   = bus.SLAVE_ADDRESS[7:1];
                    ack_ok_d = 1'b0;
                    nack_d   = 1'b0;
                    rx_d     = '0;
                    cnt_d    = '0;
                    byte_d   = '0;
                    ph_d     = '0;
                end
            end
            S_START: st_d = S_WBIT;
            S_WBIT: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d = '0;
                    if (cnt_q != 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else begin
                        cnt_d = '0;
                        if (bus.SDAI) begin
                            nack_d = 1'b1;
                            st_d   = S_STOP;
                        end else if (byte_q == 3'd2) begin
                            st_d = S_RSTART;
                        end else if (byte_q == 3'd3) begin
                            st_d   = S_RBIT;
                            byte_d = 3'd4;
                        end else begin
                            byte_d = byte_q + 3'd1;
                        end
                    end
                end
            end
            S_RSTART: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d   = '0;
                    cnt_d  = '0;
                    byte_d = 3'd3;
                    st_d   = S_WBIT;
                end
            end
            S_RBIT: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d = '0;
                    if (cnt_q != 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                        rx_d  = {rx_q[14:0], bus.SDAI};
                    end else begin
                        cnt_d = '0;
                        if (byte_q == LAST_BYTE) begin
                            st_d    = S_STOP;
                            rdata_d = rx_q;
                        end else begin
                            byte_d = byte_q + 3'd1;
                        end
                    end
                end
            end
            S_STOP: begin
                if (ph_q != 2'd2) begin
                    ph_d = ph_q + 2'd1;
                end else begin
                    ph_d     = '0;
                    st_d     = S_DONE;
                    ack_ok_d = ~nack_q;
                end
            end
            S_DONE: begin
                // Held GO parks here so one request yields one transaction.
                if (!bus.GO) st_d = S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
        {scl_d, sda_d} = bus_f(st_d, ph_d, cnt_d, byte_d, ptr_d, addr_d);
        end_ok_d = (st_d == S_IDLE) || (st_d == S_DONE);
    end

    always_ff @(posedge PT_CK) begin
        if (RESET) begin
            st_q     <= S_IDLE;
            ph_q     <= '0;
            cnt_q    <= '0;
            byte_q   <= '0;
            ptr_q    <= '0;
            addr_q   <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            nack_q   <= 1'b0;
            ack_ok_q <= 1'b0;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
            end_ok_q <= 1'b1;
        end else begin
            st_q     <= st_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            ptr_q    <= ptr_d;
            addr_q   <= addr_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            ack_ok_q <= ack_ok_d;
            sda_q    <= sda_d;
            scl_q    <= scl_d;
            end_ok_q <= end_ok_d;
        end
    end

    assign bus.SDAO   = sda_q;
    assign bus.SCLO   = scl_q;
    assign bus.END_OK = end_ok_q;
    assign bus.RDATA  = rdata_q;
    assign bus.ACK_OK = ack_ok_q;
    assign bus.ST     = st_q;
    assign bus.CNT    = cnt_q;
    assign bus.BYTE   = byte_q;
endmodule

// File: tb/tb_i2c_read_2byte_c.sv
// Bench for i2c_read_2byte_c: bus-level slave model with scoreboard
// queues, table of transactions, hold-GO and mid-read reset sequences.
module tb_i2c_read_2byte_c;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_read_2byte_c_if if0();
    i2c_read_2byte_c_if if1();

    i2c_read_2byte_c #(.RD_BYTES(2)) dut0 (.PT_CK(clk), .RESET(rst), .bus(if0));
    i2c_read_2byte_c #(.RD_BYTES(1)) dut1 (.PT_CK(clk), .RESET(rst), .bus(if1));

    int errors = 0;
    int checks = 0;

    bit sel = 1'b0;
    bit mon_en = 1'b0;
    bit nack_addr = 1'b0;
    logic slv_sda = 1'b1;

    logic [7:0] exp_bytes[$];
    logic [7:0] rd_q[$];
    bit         exp_mack[$];

    assign if0.SDAI = if0.SDAO & (sel | slv_sda);
    assign if1.SDAI = if1.SDAO & (~sel | slv_sda);

    logic bus_scl, bus_sda, endok, ackok;
    logic [15:0] rdata;
    logic [3:0] st;
    assign bus_scl = sel ? if1.SCLO : if0.SCLO;
    assign bus_sda = sel ? if1.SDAI : if0.SDAI;
    assign endok   = sel ? if1.END_OK : if0.END_OK;
    assign ackok   = sel ? if1.ACK_OK : if0.ACK_OK;
    assign rdata   = sel ? if1.RDATA : if0.RDATA;
    assign st      = sel ? if1.ST : if0.ST;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Slave model and protocol monitor, sampled on the inactive edge.
    int n_start = 0, n_stop = 0;
    logic pscl = 1'b1, psda = 1'b1;
    bit active = 0, reading = 0, rd_done = 0, hv = 0, lv = 0;
    int bitn = 0, bidx = 0, hcnt = 0, lcnt = 0;
    logic [7:0] shreg = '0, cur = '0;

    always @(negedge clk) begin
        if (!mon_en) begin
            active = 0; slv_sda = 1'b1; hv = 0; lv = 0;
        end else if (pscl && bus_scl && psda && !bus_sda) begin
            n_start++; active = 1; bitn = 0; bidx = 0;
            reading = 0; rd_done = 0; hv = 0;
        end else if (pscl && bus_scl && !psda && bus_sda) begin
            n_stop++; active = 0; hv = 0; slv_sda = 1'b1;
        end else if (!pscl && bus_scl) begin
            if (lv) chk("scl_low_run", lcnt, 1);
            hcnt = 1; hv = 1;
            if (active) begin
                if (bitn == 8) begin
                    if (reading && bidx != 0) begin
                        if (exp_mack.size() == 0) chk("mack_extra", 1, 0);
                        else chk("master_ack", bus_sda, exp_mack.pop_front());
                        if (bus_sda) rd_done = 1;
                    end
                    bitn = 0; bidx++;
                end else begin
                    shreg = {shreg[6:0], bus_sda};
                    bitn++;
                    if (bitn == 8 && !(reading && bidx != 0)) begin
                        if (exp_bytes.size() == 0) chk("byte_extra", shreg, 0);
                        else chk("bus_byte", shreg, exp_bytes.pop_front());
                        if (bidx == 0) reading = shreg[0];
                    end
                end
            end
        end else if (pscl && !bus_scl) begin
            if (hv) chk("scl_high_run", hcnt, 2);
            lcnt = 1; lv = 1;
            if (active) begin
                if (reading && bidx != 0) begin
                    if (bitn == 0) begin
                        if (rd_done || rd_q.size() == 0) cur = 8'hFF;
                        else cur = rd_q.pop_front();
                    end
                    slv_sda = (bitn < 8 && !rd_done) ? cur[7-bitn] : 1'b1;
                end else begin
                    slv_sda = (bitn == 8) ? (nack_addr && bidx == 0) : 1'b1;
                end
            end
        end else if (bus_scl) begin
            hcnt++;
        end else begin
            lcnt++;
        end
        pscl = bus_scl;
        psda = bus_sda;
    end

    typedef struct {
        bit          sel;
        logic [7:0]  addr;
        logic [15:0] ptr;
        logic [7:0]  d0, d1;
        bit          nack;
        int          lat;
        logic [15:0] rdata;
        bit          ack;
    } vec_t;

    vec_t vecs[5];

    task automatic drive(input bit go, input logic [15:0] p, input logic [7:0] a);
        if0.GO = go && !sel;
        if1.GO = go && sel;
        if0.POINTER = p; if1.POINTER = p;
        if0.SLAVE_ADDRESS = a; if1.SLAVE_ADDRESS = a;
    endtask

    task automatic run_txn(input vec_t v, input bit hold);
        int n, s0, p0;
        logic [7:0] a;
        sel = v.sel;
        nack_addr = v.nack;
        a = {v.addr[7:1], 1'b0};
        exp_bytes.push_back(a);
        if (!v.nack) begin
            exp_bytes.push_back(v.ptr[15:8]);
            exp_bytes.push_back(v.ptr[7:0]);
            exp_bytes.push_back(a | 8'h01);
            rd_q.push_back(v.d0);
            if (!v.sel) begin
                rd_q.push_back(v.d1);
                exp_mack.push_back(1'b0);
            end
            exp_mack.push_back(1'b1);
        end
        s0 = n_start;
        p0 = n_stop;
        @(negedge clk);
        drive(1'b1, v.ptr, v.addr);
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_go", endok, 0);
        chk("ack_clr_at_start", ackok, 0);
        chk("st_start", st, 1);
        drive(hold, ~v.ptr, ~v.addr);
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (endok) break;
        end
        chk("latency", n, v.lat);
        chk("rdata", rdata, v.rdata);
        chk("ack_ok", ackok, v.ack);
        chk("st_done", st, 6);
        chk("starts", n_start - s0, v.nack ? 1 : 2);
        chk("stops", n_stop - p0, 1);
        chk("bytes_left", exp_bytes.size(), 0);
        chk("macks_left", exp_mack.size(), 0);
        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("back_idle", st, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int s0, n;
        bit hit;
        vecs[0] = '{0, 8'h6C, 16'h300A, 8'h56, 8'h40, 0, 169, 16'h5640, 1};
        vecs[1] = '{0, 8'h6C, 16'h1234, 8'h00, 8'h00, 1, 31,  16'h5640, 0};
        vecs[2] = '{0, 8'h21, 16'hFFFF, 8'h00, 8'hFF, 0, 169, 16'h00FF, 1};
        vecs[3] = '{1, 8'h6C, 16'h300A, 8'hA5, 8'h00, 0, 142, 16'h00A5, 1};
        vecs[4] = '{0, 8'h42, 16'h0001, 8'h81, 8'h7E, 0, 169, 16'h817E, 1};

        drive(1'b0, 16'h0, 8'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sdao", if0.SDAO, 1);
        chk("rst_sclo", if0.SCLO, 1);
        chk("rst_endok", if0.END_OK, 1);
        chk("rst_ackok", if0.ACK_OK, 0);
        chk("rst_rdata", if0.RDATA, 0);
        chk("rst_st", if0.ST, 0);
        chk("rst_endok1", if1.END_OK, 1);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        foreach (vecs[i]) run_txn(vecs[i], 1'b0);

        // Held GO must park in DONE; a fresh edge starts a new read.
        run_txn(vecs[0], 1'b1);
        s0 = n_start;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("hold_st_done", st, 6);
        chk("hold_no_start", n_start - s0, 0);
        drive(1'b0, 16'h0, 8'h0);
        @(posedge clk);
        @(negedge clk);
        chk("drop_go_idle", st, 0);
        chk("ack_kept", ackok, 1);
        run_txn(vecs[4], 1'b0);

        // Synchronous reset in the middle of the first read byte.
        sel = 1'b0;
        nack_addr = 1'b0;
        exp_bytes.push_back(8'h6C);
        exp_bytes.push_back(8'h30);
        exp_bytes.push_back(8'h0A);
        exp_bytes.push_back(8'h6D);
        rd_q.push_back(8'h12);
        rd_q.push_back(8'h34);
        @(negedge clk);
        drive(1'b1, 16'h300A, 8'h6C);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 16'h300A, 8'h6C);
        hit = 0;
        n = 0;
        while (n < 300 && !hit) begin
            @(negedge clk);
            n++;
            hit = (if0.ST == 4 && if0.BYTE == 4 && if0.CNT == 3);
        end
        chk("reach_rbit", hit, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_sdao", if0.SDAO, 1);
        chk("mid_rst_sclo", if0.SCLO, 1);
        chk("mid_rst_endok", if0.END_OK, 1);
        chk("mid_rst_rdata", if0.RDATA, 0);
        chk("mid_rst_st", if0.ST, 0);
        chk("mid_rst_cnt", if0.CNT, 0);
        chk("mid_rst_byte", if0.BYTE, 0);
        chk("mid_rst_ackok", if0.ACK_OK, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("post_rst_idle", if0.ST, 0);
        chk("post_rst_endok", if0.END_OK, 1);
        chk("pre_rst_bytes", exp_bytes.size(), 0);
        rd_q.delete();
        exp_mack.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
